// File: rtl/xif_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xif_sched_pkg
// Description : Shared types for the CV-X-IF issue scheduler: control FSM
//               state encoding, the per-entry control record and the default
//               accepted major opcode (custom-0), plus an instruction decode
//               helper used at push time.
// Revision    : 1.0 - initial release
// ============================================================================
package xif_sched_pkg;

    // Default accepted major opcode: custom-0
    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;

    // Control FSM states (explicit 3-bit encoding)
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_COMMIT = 3'd1,
        ST_DISPATCH    = 3'd2,
        ST_EXECUTE     = 3'd3,
        ST_RESULT      = 3'd4
    } sched_state_e;

    // Width-independent part of a queue entry. The id and operand fields
    // depend on the block parameters and are held alongside this record.
    typedef struct packed {
        logic [4:0] rd;     // destination register
        logic [9:0] funct;  // {funct7, funct3}
    } entry_ctl_t;

    // Extract the control record from an R-type encoded instruction
    function automatic entry_ctl_t decode_ctl(input logic [31:0] instr);
        entry_ctl_t ctl;
        ctl.rd    = instr[11:7];
        ctl.funct = {instr[31:25], instr[14:12]};
        return ctl;
    endfunction

endpackage : xif_sched_pkg
`default_nettype wire

// File: rtl/xif_sched_queue.sv
`default_nettype none
// ============================================================================
// Module      : xif_sched_queue
// Description : In-order circular buffer of offloaded instructions. Each
//               occupied entry carries commit/kill flags that are set by id
//               match on the commit channel, including the entry being pushed
//               in the same cycle.
// Ports       : i_push/i_push_*   - write a new entry at the tail
//               i_pop             - retire the head entry
//               i_commit_*        - commit/kill strobe with id
//               o_head_*          - head entry contents and flags
//               o_count           - number of occupied entries
// Revision    : 1.0 - initial release
// ============================================================================
module xif_sched_queue
    import xif_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int XLEN  = 32,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_push,
    input  logic [ID_W-1:0]   i_push_id,
    input  entry_ctl_t        i_push_ctl,
    input  logic [XLEN-1:0]   i_push_rs1,
    input  logic [XLEN-1:0]   i_push_rs2,
    input  logic              i_pop,
    input  logic              i_commit_valid,
    input  logic [ID_W-1:0]   i_commit_id,
    input  logic              i_commit_kill,
    output logic [ID_W-1:0]   o_head_id,
    output entry_ctl_t        o_head_ctl,
    output logic [XLEN-1:0]   o_head_rs1,
    output logic [XLEN-1:0]   o_head_rs2,
    output logic              o_head_committed,
    output logic              o_head_killed,
    output logic [CNT_W-1:0]  o_count
);

    logic [ID_W-1:0]  r_id  [DEPTH];
    entry_ctl_t       r_ctl [DEPTH];
    logic [XLEN-1:0]  r_rs1 [DEPTH];
    logic [XLEN-1:0]  r_rs2 [DEPTH];
    logic [DEPTH-1:0] r_occ;
    logic [DEPTH-1:0] r_cmt;
    logic [DEPTH-1:0] r_kill;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    // A commit that targets the id being pushed this cycle lands on the new entry
    logic w_push_match;
    assign w_push_match = i_commit_valid && (i_commit_id == i_push_id);

    // Payload storage needs no reset: occupancy qualifies every read
    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_id[r_tail]  <= i_push_id;
            r_ctl[r_tail] <= i_push_ctl;
            r_rs1[r_tail] <= i_push_rs1;
            r_rs2[r_tail] <= i_push_rs2;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_occ   <= '0;
            r_cmt   <= '0;
            r_kill  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_commit_valid && r_occ[i] && (r_id[i] == i_commit_id)) begin
                    if (i_commit_kill) begin
                        r_kill[i] <= 1'b1;
                    end else begin
                        r_cmt[i] <= 1'b1;
                    end
                end
            end
            // The tail slot is never occupied when pushing, so these
            // assignments never collide with the id-match updates above.
            if (i_push) begin
                r_occ[r_tail]  <= 1'b1;
                r_cmt[r_tail]  <= w_push_match && !i_commit_kill;
                r_kill[r_tail] <= w_push_match && i_commit_kill;
                r_tail         <= r_tail + 1'b1;
            end
            if (i_pop) begin
                r_occ[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_id        = r_id[r_head];
    assign o_head_ctl       = r_ctl[r_head];
    assign o_head_rs1       = r_rs1[r_head];
    assign o_head_rs2       = r_rs2[r_head];
    assign o_head_committed = r_cmt[r_head];
    assign o_head_killed    = r_kill[r_head];
    assign o_count          = r_count;

endmodule : xif_sched_queue
`default_nettype wire

// File: rtl/xif_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : xif_issue_scheduler
// Description : Coprocessor-side CV-X-IF controller. Accepts custom-0
//               instructions on the issue channel, queues them in order,
//               waits for commit/kill, dispatches committed ones to the EXU
//               one at a time and returns results with valid/ready.
// Ports       : issue_*   - issue request/response (response combinational)
//               commit_*  - commit/kill strobe by id
//               exu_*     - dispatch handshake, done pulse and result
//               result_*  - result channel, held stable until accepted
//               busy_o    - any entry queued or FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module xif_issue_scheduler
    import xif_sched_pkg::*;
#(
    parameter int         X_ID_WIDTH = 4,
    parameter int         X_NUM_RS   = 2,
    parameter int         XLEN       = 32,
    parameter int         DEPTH      = 4,
    parameter logic [6:0] OPCODE     = OPCODE_CUSTOM0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic [31:0]                issue_req_instr_i,
    input  logic [X_ID_WIDTH-1:0]      issue_req_id_i,
    input  logic [X_NUM_RS*XLEN-1:0]   issue_req_rs_i,
    input  logic [X_NUM_RS-1:0]        issue_req_rs_valid_i,
    output logic                       issue_resp_accept_o,
    output logic                       issue_resp_writeback_o,
    input  logic                       commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]      commit_id_i,
    input  logic                       commit_kill_i,
    output logic                       exu_valid_o,
    input  logic                       exu_ready_i,
    output logic [9:0]                 exu_funct_o,
    output logic [XLEN-1:0]            exu_op_a_o,
    output logic [XLEN-1:0]            exu_op_b_o,
    input  logic                       exu_done_i,
    input  logic [XLEN-1:0]            exu_result_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [X_ID_WIDTH-1:0]      result_id_o,
    output logic [XLEN-1:0]            result_data_o,
    output logic [4:0]                 result_rd_o,
    output logic                       result_we_o,
    output logic                       busy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // ---------------- issue decode ----------------
    logic             w_accept;
    logic [4:0]       w_rd;
    logic             w_not_full;
    logic             w_rs_ok;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count;
    logic             w_unused_instr;

    assign w_accept   = (issue_req_instr_i[6:0] == OPCODE);
    assign w_rd       = issue_req_instr_i[11:7];
    assign w_not_full = (w_count < CNT_W'(DEPTH));
    assign w_rs_ok    = &issue_req_rs_valid_i;
    // Register-index fields are not needed: operand values arrive on the port
    assign w_unused_instr = ^issue_req_instr_i[24:15];

    // Responses are qualified by issue_valid_i so they idle low
    assign issue_resp_accept_o    = issue_valid_i && w_accept;
    assign issue_resp_writeback_o = issue_valid_i && w_accept && (w_rd != 5'd0);
    // Non-accepted instructions are always taken (and dropped) immediately
    assign issue_ready_o          = issue_valid_i && (w_accept ? (w_not_full && w_rs_ok) : 1'b1);
    assign w_push                 = issue_valid_i && w_accept && w_not_full && w_rs_ok;

    // ---------------- entry queue ----------------
    logic [X_ID_WIDTH-1:0] w_head_id;
    entry_ctl_t            w_head_ctl;
    logic [XLEN-1:0]       w_head_rs1;
    logic [XLEN-1:0]       w_head_rs2;
    logic                  w_head_committed;
    logic                  w_head_killed;

    xif_sched_queue #(
        .DEPTH (DEPTH),
        .ID_W  (X_ID_WIDTH),
        .XLEN  (XLEN)
    ) u_queue (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .i_push           (w_push),
        .i_push_id        (issue_req_id_i),
        .i_push_ctl       (decode_ctl(issue_req_instr_i)),
        .i_push_rs1       (issue_req_rs_i[XLEN-1:0]),
        .i_push_rs2       (issue_req_rs_i[2*XLEN-1:XLEN]),
        .i_pop            (w_pop),
        .i_commit_valid   (commit_valid_i),
        .i_commit_id      (commit_id_i),
        .i_commit_kill    (commit_kill_i),
        .o_head_id        (w_head_id),
        .o_head_ctl       (w_head_ctl),
        .o_head_rs1       (w_head_rs1),
        .o_head_rs2       (w_head_rs2),
        .o_head_committed (w_head_committed),
        .o_head_killed    (w_head_killed),
        .o_count          (w_count)
    );

    // ---------------- control FSM ----------------
    sched_state_e          r_state;
    logic                  r_exu_valid;
    logic [9:0]            r_exu_funct;
    logic [XLEN-1:0]       r_exu_op_a;
    logic [XLEN-1:0]       r_exu_op_b;
    logic                  r_result_valid;
    logic [X_ID_WIDTH-1:0] r_result_id;
    logic [XLEN-1:0]       r_result_data;
    logic [4:0]            r_result_rd;
    logic                  r_result_we;

    // Head leaves the queue when killed or when its result is taken
    assign w_pop = ((r_state == ST_WAIT_COMMIT) && w_head_killed) ||
                   ((r_state == ST_RESULT) && result_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_exu_valid    <= 1'b0;
            r_exu_funct    <= '0;
            r_exu_op_a     <= '0;
            r_exu_op_b     <= '0;
            r_result_valid <= 1'b0;
            r_result_id    <= '0;
            r_result_data  <= '0;
            r_result_rd    <= '0;
            r_result_we    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Looking at the push as well lets a fresh entry reach
                    // WAIT_COMMIT on the cycle it lands in the queue.
                    if ((w_count != '0) || w_push) begin
                        r_state <= ST_WAIT_COMMIT;
                    end
                end
                ST_WAIT_COMMIT: begin
                    if (w_head_killed) begin
                        r_state <= ST_IDLE;
                    end else if (w_head_committed) begin
                        r_state     <= ST_DISPATCH;
                        r_exu_valid <= 1'b1;
                        r_exu_funct <= w_head_ctl.funct;
                        r_exu_op_a  <= w_head_rs1;
                        r_exu_op_b  <= w_head_rs2;
                    end
                end
                ST_DISPATCH: begin
                    if (exu_ready_i) begin
                        r_exu_valid <= 1'b0;
                        r_state     <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    if (exu_done_i) begin
                        r_result_valid <= 1'b1;
                        r_result_id    <= w_head_id;
                        r_result_data  <= exu_result_i;
                        r_result_rd    <= w_head_ctl.rd;
                        r_result_we    <= (w_head_ctl.rd != 5'd0);
                        r_state        <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (result_ready_i) begin
                        r_result_valid <= 1'b0;
                        r_state        <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign exu_valid_o    = r_exu_valid;
    assign exu_funct_o    = r_exu_funct;
    assign exu_op_a_o     = r_exu_op_a;
    assign exu_op_b_o     = r_exu_op_b;
    assign result_valid_o = r_result_valid;
    assign result_id_o    = r_result_id;
    assign result_data_o  = r_result_data;
    assign result_rd_o    = r_result_rd;
    assign result_we_o    = r_result_we;
    assign busy_o         = (w_count != '0) || (r_state != ST_IDLE);

endmodule : xif_issue_scheduler
`default_nettype wire

// File: doc/xif_issue_scheduler.md
Name: xif_issue_scheduler

Overview:
Coprocessor-side controller for the CV-X-IF issue/commit/result channels of the core wrapper. It accepts offloaded custom-0 instructions, queues them in order, and holds each one until the core commits or kills it. Committed instructions are dispatched one at a time to a single-cycle-or-longer execution unit (EXU), and the results go back on the result channel with valid/ready flow control. It sits between the core's eXtension interface ports and the coprocessor datapath.

Parameters:
X_ID_WIDTH, 4, width of the instruction id
X_NUM_RS, 2, number of source register operands (fixed at 2 for this block)
XLEN, 32, register width
DEPTH, 4, number of in-flight entries (power of two, 2..16)
OPCODE, 7'b0001011, accepted major opcode (custom-0)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
issue_valid_i  in  1  issue request valid
issue_ready_o  out  1  issue request ready
issue_req_instr_i  in  32  offloaded instruction
issue_req_id_i  in  X_ID_WIDTH  instruction id
issue_req_rs_i  in  X_NUM_RS*XLEN  operands; rs[0] in the LSBs
issue_req_rs_valid_i  in  X_NUM_RS  operand valid flags
issue_resp_accept_o  out  1  instruction accepted
issue_resp_writeback_o  out  1  instruction will write rd
commit_valid_i  in  1  commit strobe
commit_id_i  in  X_ID_WIDTH  id being committed or killed
commit_kill_i  in  1  1 = kill, 0 = commit
exu_valid_o  out  1  dispatch valid
exu_ready_i  in  1  EXU ready
exu_funct_o  out  10  {funct7, funct3}
exu_op_a_o  out  XLEN  rs1 value
exu_op_b_o  out  XLEN  rs2 value
exu_done_i  in  1  single-cycle pulse, result valid
exu_result_i  in  XLEN  EXU result
result_valid_o  out  1  result valid
result_ready_i  in  1  result ready
result_id_o  out  X_ID_WIDTH  result id
result_data_o  out  XLEN  result data
result_rd_o  out  5  destination register
result_we_o  out  1  register write enable
busy_o  out  1  any entry occupied or control FSM not IDLE

Behaviour:
- Reset: all outputs 0. Queue empty, every commit flag cleared, FSM in IDLE. A reset in mid-operation drops all entries and any in-flight EXU op; the EXU must be reset by the same rst_i.
- Issue decode:
  - accept = (instr[6:0] == OPCODE).
  - issue_resp_* are combinational from issue_req_instr_i and are meaningful only while issue_valid_i is high.
  - writeback = accept && rd != 0.
- Issue ready:
  - For an accepted instruction: issue_ready_o = (count < DEPTH) && (&issue_req_rs_valid_i).
  - For a non-accepted instruction: issue_ready_o = 1 and nothing is stored.
  - count is registered, so a pop in the same cycle does not free space for a push when full.
- Push: an accepted handshake writes {id, rd, funct, rs1, rs2, committed=0, killed=0} at the tail.
- Commit handling:
  - commit_valid_i marks every occupied entry with a matching id as committed, or killed when commit_kill_i = 1.
  - A commit in the same cycle as that id's issue handshake applies to the entry being pushed.
  - An unmatched id is ignored.
- Control FSM (head entry only, strictly in order):
  - IDLE: queue non-empty → WAIT_COMMIT.
  - WAIT_COMMIT:
    - head killed → pop, no result, → IDLE.
    - head committed → DISPATCH.
  - DISPATCH: exu_valid_o = 1 with the head operands. On exu_ready_i → EXECUTE. Operands stay stable while waiting.
  - EXECUTE: on exu_done_i, register result_data and → RESULT. exu_done_i in any other state is ignored.
  - RESULT: result_valid_o = 1 and all result_* fields stay stable until result_ready_i. On the handshake, pop the head → IDLE.
- Result fields: result_we_o = (rd != 0). Every accepted, non-killed instruction produces exactly one result.
- Latency: with issue and commit at cycle T and exu_ready_i = 1, exu_valid_o rises at T+2 (IDLE and WAIT_COMMIT each take one cycle). exu_done at cycle D gives result_valid_o at D+1.
- Pointers: head and tail wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits wide.

Decomposition:
- Package xif_sched_pkg: state enum (IDLE, WAIT_COMMIT, DISPATCH, EXECUTE, RESULT), the entry struct typedef, and the OPCODE default.
- One sub-module, xif_sched_queue: circular buffer holding the entries plus per-entry commit/kill flags with id match, exposing push/pop/head/count.

Test Plan:
- Issue instr 0x0020818B (custom-0, rd=3), id=2, rs={5,7}, then commit id=2 at T+1, EXU returns 12 one cycle after dispatch → result_valid_o with id=2, rd=3, data=12, we=1; busy_o is 0 two cycles later.
- Issue an opcode-0x33 instruction → issue_ready_o=1, accept=0, writeback=0; no entry created, busy_o stays 0.
- Issue ids 0..3 with no commit → 5th issue sees issue_ready_o=0. Kill id 0, commit ids 1..3 → exactly 3 results in order 1, 2, 3; the 5th issue is then accepted.
- Commit in the same cycle as issue of id=5, with result_ready_i held low for 4 cycles → result stable for all 4 cycles, popped on the handshake.
- Issue with rs_valid=2'b01 → issue_ready_o=0 until rs_valid=2'b11.
- Assert rst_i while in EXECUTE → next cycle all outputs 0, count=0; a following exu_done_i pulse produces no result.
